// File: rtl/ahb_apb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_apb_pkg
// Shared definitions for the AHB-Lite to APB bridge:
//   - AHB Htrans encodings
//   - bridge FSM state type
//   - address windows of the three APB peripherals
//   - OKAY response code
//   - slave_sel(): address -> one-hot APB select (0 when out of range)
// ----------------------------------------------------------------------------
package ahb_apb_pkg;

  // AHB transfer types
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  // AHB response
  localparam logic [1:0] HRESP_OKAY = 2'b00;

  // Number of APB peripherals behind the bridge
  localparam int NUM_SLV = 3;

  // Bridge FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WWAIT  = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ENABLE = 2'd3
  } state_t;

  // Peripheral address windows (inclusive limits)
  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  // One-hot select for an address; all-zero means "not ours".
  function automatic logic [NUM_SLV-1:0] slave_sel(input logic [31:0] addr);
    logic [NUM_SLV-1:0] sel;
    sel = '0;
    if (addr >= SLV0_BASE && addr <= SLV0_LIMIT) sel = 3'b001;
    if (addr >= SLV1_BASE && addr <= SLV1_LIMIT) sel = 3'b010;
    if (addr >= SLV2_BASE && addr <= SLV2_LIMIT) sel = 3'b100;
    return sel;
  endfunction

endpackage

// File: rtl/ahb_apb_modport_decode.sv
// ----------------------------------------------------------------------------
// ahb_slave_decode
// AHB address-phase decode and transfer pipeline registers.
//
// Ports:
//   i_clk, i_rst_n   clock / asynchronous active-low reset
//   i_htrans         AHB transfer type
//   i_haddr          AHB address
//   i_hwrite         AHB direction
//   i_hreadyin       interconnect ready
//   i_hwdata         AHB write data (data phase)
//   i_accept         capture address/direction/select this cycle
//   i_load_wdata     capture Hwdata this cycle
//   o_valid          current address phase is a transfer for this bridge
//   o_sel            one-hot select decoded from the current address
//   o_addr_q         latched address  (drives Paddr)
//   o_write_q        latched direction (drives Pwrite)
//   o_sel_q          latched select
//   o_wdata_q        latched write data (drives Pwdata)
// ----------------------------------------------------------------------------
module ahb_slave_decode
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_htrans,
  input  logic [ADDR_W-1:0]  i_haddr,
  input  logic               i_hwrite,
  input  logic               i_hreadyin,
  input  logic [DATA_W-1:0]  i_hwdata,
  input  logic               i_accept,
  input  logic               i_load_wdata,
  output logic               o_valid,
  output logic [NUM_SLV-1:0] o_sel,
  output logic [ADDR_W-1:0]  o_addr_q,
  output logic               o_write_q,
  output logic [NUM_SLV-1:0] o_sel_q,
  output logic [DATA_W-1:0]  o_wdata_q
);

  logic [31:0]        w_addr32;
  logic [NUM_SLV-1:0] w_sel;
  logic               w_active;

  logic [ADDR_W-1:0]  r_addr;
  logic               r_write;
  logic [NUM_SLV-1:0] r_sel;
  logic [DATA_W-1:0]  r_wdata;

  assign w_addr32 = 32'(i_haddr);
  assign w_sel    = slave_sel(w_addr32);
  // Only NONSEQ/SEQ carry a transfer; IDLE and BUSY are dropped here.
  assign w_active = (i_htrans == HT_NONSEQ) || (i_htrans == HT_SEQ);
  assign o_valid  = i_hreadyin && w_active && (w_sel != '0);
  assign o_sel    = w_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_sel   <= '0;
    end else if (i_accept) begin
      r_addr  <= i_haddr;
      r_write <= i_hwrite;
      r_sel   <= w_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdata <= '0;
    end else if (i_load_wdata) begin
      r_wdata <= i_hwdata;
    end
  end

  assign o_addr_q  = r_addr;
  assign o_write_q = r_write;
  assign o_sel_q   = r_sel;
  assign o_wdata_q = r_wdata;

endmodule

// File: rtl/ahb_apb_modport.sv
// ----------------------------------------------------------------------------
// ahb_apb_modport
// AHB-Lite slave to APB master bridge for three peripherals. Each accepted
// AHB beat becomes one APB SETUP/ENABLE transfer; the AHB data phase is
// stretched with Hreadyout and the response is always OKAY.
//
// Ports:
//   Hclk, Hresetn          clock / asynchronous active-low reset
//   Htrans, Haddr, Hwrite  AHB address phase
//   Hsize, Hburst          accepted, no effect on behaviour
//   Hwdata                 AHB write data
//   Hreadyin               interconnect ready
//   Hrdata, Hresp          AHB read data / response
//   Hreadyout              0 inserts wait states
//   Paddr, Pwdata, Pwrite  APB address / write data / direction
//   Pselx, Penable         APB one-hot select / enable phase
//   Prdata                 APB read data
//   o_dbg_state            current FSM state, for observation
//
// Handshake: an AHB transfer is taken on a rising edge where the bridge is
// in ST_IDLE or ST_ENABLE and the decode reports valid (Hreadyin high,
// NONSEQ/SEQ, address in range). Its data phase ends on the first later
// edge that sees Hreadyout high. APB: Pselx rises with Penable low (SETUP),
// Penable is high for exactly one cycle (ENABLE), with no APB wait states.
// ----------------------------------------------------------------------------
module ahb_apb_modport
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [2:0]        Hsize,
  input  logic [2:0]        Hburst,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic              Hreadyin,
  output logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Hresp,
  output logic              Hreadyout,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic [2:0]        Pselx,
  output logic              Penable,
  input  logic [DATA_W-1:0] Prdata,
  output state_t            o_dbg_state
);

  state_t             r_state;
  logic [NUM_SLV-1:0] r_pselx;
  logic               r_penable;
  logic               r_hreadyout;

  logic               w_valid;
  logic [NUM_SLV-1:0] w_sel;
  logic               w_accept;
  logic               w_load_wdata;
  logic [NUM_SLV-1:0] w_sel_q;
  logic               w_write_q;
  logic               w_unused_ignored;

  // Size and burst type do not alter behaviour.
  assign w_unused_ignored = ^{Hsize, Hburst};

  // New transfers are only taken when the bridge is not stretching the bus.
  assign w_accept     = w_valid && ((r_state == ST_IDLE) || (r_state == ST_ENABLE));
  assign w_load_wdata = (r_state == ST_WWAIT);

  ahb_slave_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_decode (
    .i_clk        (Hclk),
    .i_rst_n      (Hresetn),
    .i_htrans     (Htrans),
    .i_haddr      (Haddr),
    .i_hwrite     (Hwrite),
    .i_hreadyin   (Hreadyin),
    .i_hwdata     (Hwdata),
    .i_accept     (w_accept),
    .i_load_wdata (w_load_wdata),
    .o_valid      (w_valid),
    .o_sel        (w_sel),
    .o_addr_q     (Paddr),
    .o_write_q    (w_write_q),
    .o_sel_q      (w_sel_q),
    .o_wdata_q    (Pwdata)
  );

  // FSM with registered APB/AHB control outputs. Outputs are loaded with the
  // values belonging to the state being entered.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state     <= ST_IDLE;
      r_pselx     <= '0;
      r_penable   <= 1'b0;
      r_hreadyout <= 1'b1;
    end else begin
      case (r_state)
        // ST_ENABLE completes the current beat and, if the next beat is
        // already on the bus, chains straight into it.
        ST_IDLE, ST_ENABLE: begin
          if (w_valid) begin
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b0;
            if (Hwrite) begin
              // Write data arrives one cycle later; select stays low meanwhile.
              r_state <= ST_WWAIT;
              r_pselx <= '0;
            end else begin
              r_state <= ST_SETUP;
              r_pselx <= w_sel;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
          end
        end
        ST_WWAIT: begin
          r_state     <= ST_SETUP;
          r_pselx     <= w_sel_q;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b0;
        end
        ST_SETUP: begin
          r_state     <= ST_ENABLE;
          r_penable   <= 1'b1;
          r_hreadyout <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_pselx     <= '0;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b1;
        end
      endcase
    end
  end

  // Read data passes straight through during the ENABLE cycle of a read.
  assign Hrdata      = ((r_state == ST_ENABLE) && !w_write_q) ? Prdata : '0;
  assign Hresp       = HRESP_OKAY;
  assign Hreadyout   = r_hreadyout;
  assign Pselx       = r_pselx;
  assign Penable     = r_penable;
  assign Pwrite      = w_write_q;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_apb_modport.sv
module tb_ahb_apb_modport;
  import ahb_apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 3 + 1 + AW + DW;
  localparam logic [31:0] RD_XOR = 32'h5A5A_F00F;

  // ---------------- clock / reset / DUT ----------------
  logic          Hclk;
  logic          Hresetn;
  logic [1:0]    Htrans;
  logic [AW-1:0] Haddr;
  logic          Hwrite;
  logic [2:0]    Hsize;
  logic [2:0]    Hburst;
  logic [DW-1:0] Hwdata;
  logic          Hreadyin;
  logic [DW-1:0] Hrdata;
  logic [1:0]    Hresp;
  logic          Hreadyout;
  logic [AW-1:0] Paddr;
  logic [DW-1:0] Pwdata;
  logic          Pwrite;
  logic [2:0]    Pselx;
  logic          Penable;
  logic [DW-1:0] Prdata;
  state_t        dbg_state;

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  ahb_apb_modport #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Hclk        (Hclk),
    .Hresetn     (Hresetn),
    .Htrans      (Htrans),
    .Haddr       (Haddr),
    .Hwrite      (Hwrite),
    .Hsize       (Hsize),
    .Hburst      (Hburst),
    .Hwdata      (Hwdata),
    .Hreadyin    (Hreadyin),
    .Hrdata      (Hrdata),
    .Hresp       (Hresp),
    .Hreadyout   (Hreadyout),
    .Paddr       (Paddr),
    .Pwdata      (Pwdata),
    .Pwrite      (Pwrite),
    .Pselx       (Pselx),
    .Penable     (Penable),
    .Prdata      (Prdata),
    .o_dbg_state (dbg_state)
  );

  // APB slave model: fixed value when forced, otherwise address-derived.
  logic        prd_fixed_en;
  logic [31:0] prd_fixed;
  assign Prdata = prd_fixed_en ? prd_fixed : (Paddr ^ RD_XOR);

  // ---------------- scoreboard state ----------------
  int checks;
  int errors;
  int xfer_cnt;
  int idle_seen;
  logic [EW-1:0] exp_q[$];

  logic [1:0]  b_tr[16];
  logic [31:0] b_addr[16];
  logic        b_wr[16];
  logic [31:0] b_wdata[16];
  int          b_wait[17];

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    case (a[31:26])
      6'b100000: return 3'b001;
      6'b100001: return 3'b010;
      6'b100010: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] rd_value(input logic [31:0] a);
    return prd_fixed_en ? prd_fixed : (a ^ RD_XOR);
  endfunction

  function automatic logic beat_valid(input int i);
    return Hreadyin && b_tr[i][1] && (exp_sel(b_addr[i]) != 3'b000);
  endfunction

  // ---------------- APB monitor / scoreboard compare ----------------
  always @(negedge Hclk) begin
    logic [2:0]  es;
    logic        ew;
    logic [31:0] ea;
    logic [31:0] ed;
    if (Hresetn && Pselx != 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_apb: got psel %b addr %h, want no APB activity", Pselx, Paddr);
      end else begin
        {es, ew, ea, ed} = exp_q[0];
        checks++;
        if ({Pselx, Pwrite, Paddr} !== {es, ew, ea} || (ew && Pwdata !== ed)) begin
          errors++;
          $display("FAIL apb_%s: got sel %b wr %b addr %h wdata %h, want sel %b wr %b addr %h wdata %h",
                   Penable ? "enable" : "setup", Pselx, Pwrite, Paddr, Pwdata, es, ew, ea, ed);
        end
        checks++;
        if (!Penable) begin
          if (Hreadyout !== 1'b0) begin
            errors++;
            $display("FAIL setup_hready: got %b want 0", Hreadyout);
          end
        end else begin
          if (Hreadyout !== 1'b1 || Hrdata !== (ew ? 32'h0 : ed)) begin
            errors++;
            $display("FAIL enable_hrdata: got ready %b rdata %h, want ready 1 rdata %h",
                     Hreadyout, Hrdata, ew ? 32'h0 : ed);
          end
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
      end
    end else if (Hresetn && Penable !== 1'b0) begin
      checks++; errors++;
      $display("FAIL penable_no_psel: got penable %b with psel %b", Penable, Pselx);
    end
  end

  // ---------------- driver ----------------
  // Runs n pipelined AHB beats from b_* arrays; entered and left at posedge+1.
  // b_wait[i] = wait states seen during the data phase of beat i-1.
  task automatic run_beats(input int n, input logic [2:0] burst);
    logic        prev_wr;
    logic [31:0] prev_wd;
    bit          rdy;
    int          w;
    prev_wr   = 1'b0;
    prev_wd   = '0;
    idle_seen = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        Htrans = b_tr[i];
        Haddr  = b_addr[i];
        Hwrite = b_wr[i];
      end else begin
        Htrans = HT_IDLE;
        Haddr  = $urandom;
        Hwrite = 1'($urandom_range(0, 1));
      end
      Hsize  = 3'd2;
      Hburst = burst;
      Hwdata = prev_wr ? prev_wd : $urandom;
      if (i < n && beat_valid(i))
        exp_q.push_back({exp_sel(b_addr[i]), b_wr[i], b_addr[i],
                         b_wr[i] ? b_wdata[i] : rd_value(b_addr[i])});
      w = 0;
      do begin
        @(negedge Hclk);
        rdy = Hreadyout;
        if (i >= 1 && i < n && dbg_state == ST_IDLE) idle_seen++;
        @(posedge Hclk);
        if (!rdy) w++;
      end while (!rdy && w < 20);
      if (w >= 20) begin
        checks++; errors++;
        $display("FAIL hready_timeout: beat %0d got %0d waits want < 20", i, w);
      end
      b_wait[i] = w;
      #1;
      prev_wr = (i < n) && beat_valid(i) && b_wr[i];
      prev_wd = (i < n) ? b_wdata[i] : '0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Hresetn = 1'b0;
    Htrans = HT_IDLE; Haddr = '0; Hwrite = 1'b0; Hsize = '0; Hburst = '0;
    Hwdata = '0; Hreadyin = 1'b1;
    repeat (3) @(posedge Hclk);
    #1;
    checks++;
    if ({Hreadyout, Pselx, Penable, Hresp, Pwrite} !== {1'b1, 3'b000, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy %b sel %b en %b resp %b wr %b, want 1 000 0 00 0",
               Hreadyout, Pselx, Penable, Hresp, Pwrite);
    end
    checks++;
    if (Hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", Hrdata); end
    checks++;
    if (Paddr !== 32'h0 || Pwdata !== 32'h0) begin
      errors++; $display("FAIL reset_paddr_pwdata: got %h %h want 0 0", Paddr, Pwdata);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
  endtask

  task automatic test_single_write();
    int c0;
    c0 = xfer_cnt;
    b_tr[0] = HT_NONSEQ; b_addr[0] = 32'h8000_0010; b_wr[0] = 1'b1; b_wdata[0] = 32'hDEAD_BEEF;
    run_beats(1, 3'b000);
    checks++;
    if (b_wait[1] !== 2) begin errors++; $display("FAIL write_waits: got %0d want 2", b_wait[1]); end
    checks++;
    if (xfer_cnt - c0 !== 1) begin errors++; $display("FAIL write_count: got %0d want 1", xfer_cnt - c0); end
    checks++;
    if (Paddr !== 32'h8000_0010 || Pwdata !== 32'hDEAD_BEEF || Pwrite !== 1'b1) begin
      errors++; $display("FAIL write_hold: got %h %h %b want 80000010 deadbeef 1", Paddr, Pwdata, Pwrite);
    end
    checks++;
    if (dbg_state !== ST_IDLE || Pselx !== 3'b000) begin
      errors++; $display("FAIL write_end_idle: got state %0d sel %b want 0 000", dbg_state, Pselx);
    end
  endtask

  task automatic test_single_read();
    prd_fixed_en = 1'b1; prd_fixed = 32'h1234_5678;
    b_tr[0] = HT_NONSEQ; b_addr[0] = 32'h8400_0020; b_wr[0] = 1'b0; b_wdata[0] = '0;
    run_beats(1, 3'b000);
    checks++;
    if (b_wait[1] !== 1) begin errors++; $display("FAIL read_waits: got %0d want 1", b_wait[1]); end
    checks++;
    if (Hrdata !== 32'h0) begin errors++; $display("FAIL read_idle_hrdata: got %h want 0", Hrdata); end
    prd_fixed_en = 1'b0;
  endtask

  task automatic test_burst_write();
    int c0;
    c0 = xfer_cnt;
    for (int i = 0; i < 4; i++) begin
      b_tr[i] = (i == 0) ? HT_NONSEQ : HT_SEQ;
      b_addr[i] = 32'h8800_0000 + 32'(4 * i);
      b_wr[i] = 1'b1;
      b_wdata[i] = $urandom;
    end
    run_beats(4, 3'b011);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (b_wait[i] !== 2) begin errors++; $display("FAIL burst_waits: beat %0d got %0d want 2", i - 1, b_wait[i]); end
    end
    checks++;
    if (xfer_cnt - c0 !== 4) begin errors++; $display("FAIL burst_count: got %0d want 4", xfer_cnt - c0); end
    checks++;
    if (idle_seen !== 0) begin errors++; $display("FAIL burst_no_idle: got %0d idle cycles want 0", idle_seen); end
  endtask

  task automatic test_back_to_back();
    b_tr[0] = HT_NONSEQ; b_addr[0] = 32'h83FF_FFFC; b_wr[0] = 1'b0; b_wdata[0] = '0;
    b_tr[1] = HT_NONSEQ; b_addr[1] = 32'h8400_0000; b_wr[1] = 1'b1; b_wdata[1] = $urandom;
    b_tr[2] = HT_NONSEQ; b_addr[2] = 32'h8BFF_FFFC; b_wr[2] = 1'b0; b_wdata[2] = '0;
    b_tr[3] = HT_NONSEQ; b_addr[3] = 32'h8000_0000; b_wr[3] = 1'b1; b_wdata[3] = $urandom;
    run_beats(4, 3'b000);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_wait[i + 1] !== (b_wr[i] ? 2 : 1)) begin
        errors++; $display("FAIL b2b_waits: beat %0d got %0d want %0d", i, b_wait[i + 1], b_wr[i] ? 2 : 1);
      end
    end
  endtask

  task automatic test_ignored();
    int c0;
    c0 = xfer_cnt;
    b_tr[0] = HT_IDLE;   b_addr[0] = 32'h8000_0000; b_wr[0] = 1'b1;
    b_tr[1] = HT_BUSY;   b_addr[1] = 32'h8000_0004; b_wr[1] = 1'b0;
    b_tr[2] = HT_NONSEQ; b_addr[2] = 32'h9000_0000; b_wr[2] = 1'b1;
    b_tr[3] = HT_NONSEQ; b_addr[3] = 32'h8C00_0000; b_wr[3] = 1'b0;
    b_tr[4] = HT_SEQ;    b_addr[4] = 32'h7FFF_FFFC; b_wr[4] = 1'b1;
    for (int i = 0; i < 5; i++) b_wdata[i] = $urandom;
    run_beats(5, 3'b000);
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (b_wait[i] !== 0) begin errors++; $display("FAIL ignored_waits: beat %0d got %0d want 0", i - 1, b_wait[i]); end
    end
    checks++;
    if (xfer_cnt !== c0 || Hresp !== 2'b00) begin
      errors++; $display("FAIL ignored_activity: got %0d xfers resp %b want 0 00", xfer_cnt - c0, Hresp);
    end
  endtask

  task automatic test_hreadyin();
    int          c0;
    logic [31:0] wd;
    Hreadyin = 1'b0; Htrans = HT_NONSEQ; Haddr = 32'h8000_0000; Hwrite = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Hclk); #1;
      checks++;
      if (dbg_state !== ST_IDLE || Pselx !== 3'b000 || Hreadyout !== 1'b1) begin
        errors++; $display("FAIL hreadyin_block: got state %0d sel %b rdy %b want 0 000 1", dbg_state, Pselx, Hreadyout);
      end
    end
    // Accepted transfer must finish even though Hreadyin drops afterwards.
    c0 = xfer_cnt;
    wd = $urandom;
    Hreadyin = 1'b1; Haddr = 32'h8400_0008;
    exp_q.push_back({3'b010, 1'b1, 32'h8400_0008, wd});
    @(posedge Hclk); #1;
    Hreadyin = 1'b0; Htrans = HT_IDLE; Hwdata = wd;
    for (int k = 0; k < 8; k++) begin
      @(posedge Hclk); #1;
      if (xfer_cnt != c0) break;
    end
    checks++;
    if (xfer_cnt !== c0 + 1) begin errors++; $display("FAIL hreadyin_nostall: got %0d xfers want 1", xfer_cnt - c0); end
    Hreadyin = 1'b1;
    @(posedge Hclk); #1;
  endtask

  task automatic test_reset_mid();
    int k;
    Htrans = HT_NONSEQ; Haddr = 32'h8000_0040; Hwrite = 1'b1;
    @(posedge Hclk); #1;
    Htrans = HT_IDLE; Hwdata = 32'hCAFE_F00D;
    k = 0;
    do begin
      @(posedge Hclk); #1;
      k++;
    end while (dbg_state != ST_SETUP && k < 6);
    checks++;
    if (dbg_state !== ST_SETUP) begin errors++; $display("FAIL mid_reach_setup: got %0d want 2", dbg_state); end
    #1 Hresetn = 1'b0;
    #1;
    checks++;
    if ({Hreadyout, Pselx, Penable, Hresp, Pwrite} !== {1'b1, 3'b000, 1'b0, 2'b00, 1'b0} ||
        Paddr !== 32'h0 || Pwdata !== 32'h0 || Hrdata !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_reset: got rdy %b sel %b en %b wr %b addr %h wdata %h state %0d, want 1 000 0 0 0 0 0",
               Hreadyout, Pselx, Penable, Pwrite, Paddr, Pwdata, dbg_state);
    end
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
  endtask

  task automatic test_random();
    int c0;
    int n_exp;
    int r;
    c0 = xfer_cnt;
    n_exp = 0;
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 5);
      b_tr[i] = (r == 0) ? HT_IDLE : (r == 1) ? HT_BUSY : (r[0] ? HT_NONSEQ : HT_SEQ);
      r = $urandom_range(0, 4);
      case (r)
        0: b_addr[i] = 32'h8000_0000 | {14'd0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
        1: b_addr[i] = 32'h8400_0000 | {14'd0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
        2: b_addr[i] = 32'h8800_0000 | {14'd0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
        3: b_addr[i] = 32'h9000_0000 | {14'd0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
        default: b_addr[i] = 32'h7FFF_FFF0;
      endcase
      b_wr[i] = 1'($urandom_range(0, 1));
      b_wdata[i] = $urandom;
      if (beat_valid(i)) n_exp++;
    end
    run_beats(12, 3'($urandom_range(0, 7)));
    checks++;
    if (xfer_cnt - c0 !== n_exp) begin errors++; $display("FAIL random_count: got %0d want %0d", xfer_cnt - c0, n_exp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; errors = 0; xfer_cnt = 0; idle_seen = 0;
    prd_fixed_en = 1'b0; prd_fixed = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write();
    test_back_to_back();
    test_ignored();
    test_hreadyin();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_apb_modport.md
Name: ahb_apb_modport

Overview:
- AHB-Lite slave to APB master bridge; sits between the AHB bus and three APB peripherals.
- Accepts AHB single and burst beats and converts each beat into one APB SETUP/ENABLE transfer.
- Stretches the AHB data phase with Hreadyout; always returns OKAY.
- Hsize and Hburst are accepted but do not change behaviour; every beat is an independent 32-bit APB transfer.

Parameters:
- ADDR_W, 32, AHB/APB address width
- DATA_W, 32, AHB/APB data width

Ports:
- Hclk  in  1  clock; all state updates on rising edge
- Hresetn  in  1  asynchronous active-low reset
- Htrans  in  2  AHB transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- Haddr  in  ADDR_W  AHB address
- Hwrite  in  1  1 = write, 0 = read
- Hsize  in  3  transfer size; ignored
- Hburst  in  3  burst type; ignored
- Hwdata  in  DATA_W  AHB write data, valid in the data phase
- Hreadyin  in  1  bus ready from the AHB interconnect
- Hrdata  out  DATA_W  read data to AHB
- Hresp  out  2  response; constant 2'b00 (OKAY)
- Hreadyout  out  1  slave ready; 0 inserts wait states
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Pwrite  out  1  APB direction
- Pselx  out  3  one-hot APB slave select
- Penable  out  1  APB enable phase
- Prdata  in  DATA_W  APB read data

Behaviour:
- valid = Hreadyin & Htrans[1] & Haddr in 0x8000_0000..0x8BFF_FFFF.
- Slave decode:
  - 0x8000_0000–0x83FF_FFFF -> Pselx 3'b001
  - 0x8400_0000–0x87FF_FFFF -> 3'b010
  - 0x8800_0000–0x8BFF_FFFF -> 3'b100
- IDLE, BUSY and out-of-range transfers are ignored: no APB activity, Hreadyout stays 1, Hresp OKAY.
- State machine states: ST_IDLE, ST_WWAIT, ST_SETUP, ST_ENABLE.
- ST_IDLE:
  - Hreadyout = 1.
  - On valid, register Haddr, Hwrite and the decoded select.
  - Next state: write -> ST_WWAIT; read -> ST_SETUP.
- ST_WWAIT:
  - Hreadyout = 0.
  - Register Hwdata into Pwdata.
  - Next state: ST_SETUP.
- ST_SETUP:
  - Pselx = latched select, Penable = 0, Paddr and Pwrite driven from the latched values.
  - Hreadyout = 0.
  - Next state: ST_ENABLE.
- ST_ENABLE:
  - Pselx held, Penable = 1, Hreadyout = 1.
  - Read: Hrdata = Prdata (combinational) in this cycle.
  - If valid in this cycle, latch the new transfer and go to ST_WWAIT or ST_SETUP (pipelined back-to-back); otherwise go to ST_IDLE.
- Latency, counted from the address-phase accept edge T0:
  - read: Penable high in T2, data returned in T2
  - write: Pwdata loaded at T1, Penable high in T3
- Outside ST_ENABLE-read, Hrdata = 0.
- Paddr, Pwrite and Pwdata hold their last values when idle.
- Pselx and Penable are 0 in ST_IDLE and ST_WWAIT.
- Reset asserted (asynchronous, any time, including mid-transfer):
  - state -> ST_IDLE
  - Hreadyout = 1, Hresp = 0, Hrdata = 0
  - Pselx = 0, Penable = 0, Pwrite = 0, Paddr = 0, Pwdata = 0
  - any in-flight transfer is dropped
- Hreadyin = 0 blocks acceptance of a new transfer but does not stall an in-progress APB transfer.

Decomposition:
- Package ahb_apb_pkg holds:
  - Htrans encodings (HT_IDLE/BUSY/NONSEQ/SEQ)
  - state enum
  - slave address range base/limit constants
  - Hresp OKAY constant
- One sub-module, ahb_slave_decode: computes valid and the one-hot select, and holds the address/write/data pipeline registers.
- The FSM and APB drive stay in the top level.

Test Plan:
- Reset: hold Hresetn = 0 -> Hreadyout = 1, Pselx = 0, Penable = 0, Hresp = 0. Assert reset during ST_SETUP -> outputs return to reset values immediately.
- Single write: Haddr = 0x8000_0010, Hwrite = 1, Htrans = 2, Hwdata = 0xDEAD_BEEF -> Pselx = 001 and Paddr = 0x8000_0010 with Pwdata = 0xDEAD_BEEF in SETUP then ENABLE; Hreadyout low for 2 cycles.
- Single read: Haddr = 0x8400_0020, Prdata = 0x1234_5678 -> Pselx = 010; Hrdata = 0x1234_5678 with Hreadyout = 1 in the ENABLE cycle.
- INCR4 write burst at 0x8800_0000 (SEQ beats +4) -> four APB transfers with Pselx = 100, back to back with no return to IDLE.
- Ignored traffic: Htrans = IDLE or BUSY, or Haddr = 0x9000_0000 -> no Pselx activity, Hreadyout = 1, Hresp = 00.
- Hreadyin = 0 with Htrans = NONSEQ -> transfer not accepted, FSM stays in ST_IDLE.
